// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the RV32I front end: fetch FSM states,
// the bubble encoding and the IF/ID pipeline register payload.
package fetch_stage_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// Generic pipeline register between two stages: flush beats stall, stall beats
// load, and an idle cycle loads a bubble while keeping the PC fields.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] BUBBLE_INSTR = NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   stall,
    input  logic   flush,
    input  logic   load,
    input  if_id_t load_data,
    output if_id_t q
);

    if_id_t ifid_q;
    if_id_t ifid_d;

    always_comb begin
        ifid_d = ifid_q;
        if (flush) begin
            ifid_d.instr = BUBBLE_INSTR;
            ifid_d.valid = 1'b0;
        end else if (!stall) begin
            if (load) begin
                ifid_d = load_data;
            end else begin
                ifid_d.instr = BUBBLE_INSTR;
                ifid_d.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_q <= '{instr: BUBBLE_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign q = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with a single-outstanding imem handshake, redirect
// handling and a one-entry hold buffer feeding the IF/ID register.
module fetch_stage #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = fetch_stage_pkg::NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  StallF,
    input  logic                  StallD,
    input  logic                  FlushD,
    input  logic                  PCSrcE,
    input  logic [DATA_WIDTH-1:0] PCTargetE,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] PCF,
    output logic [DATA_WIDTH-1:0] InstrD,
    output logic [DATA_WIDTH-1:0] PCD,
    output logic [DATA_WIDTH-1:0] PCPlus4D,
    output logic                  ValidD
);

    import fetch_stage_pkg::*;

    localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

    fetch_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] pcf_q, pcf_d;
    logic [DATA_WIDTH-1:0] hold_instr_q, hold_instr_d;
    logic [DATA_WIDTH-1:0] hold_pc_q, hold_pc_d;
    logic                  grace_q, grace_d;
    logic [DATA_WIDTH-1:0] target_aligned;
    logic [DATA_WIDTH-1:0] pcf_plus4;
    logic                  req;
    logic                  ifid_load;
    if_id_t                ifid_load_data;
    if_id_t                ifid_out;

    assign target_aligned = PCTargetE & ALIGN_MASK;
    assign pcf_plus4      = pcf_q + PC_STEP;

    always_comb begin
        state_d        = state_q;
        pcf_d          = pcf_q;
        hold_instr_d   = hold_instr_q;
        hold_pc_d      = hold_pc_q;
        req            = 1'b0;
        ifid_load      = 1'b0;
        ifid_load_data = '{instr: imem_rdata, pc: pcf_q, pc_plus4: pcf_plus4, valid: 1'b1};

        unique case (state_q)
            FETCH: begin
                if (PCSrcE) begin
                    pcf_d = target_aligned;
                end else if (!StallF && rst_n) begin
                    req     = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A redirect kills the in-flight fetch even if its data lands now.
                if (PCSrcE) begin
                    pcf_d   = target_aligned;
                    state_d = imem_rvalid ? FETCH : DROP;
                end else if (imem_rvalid) begin
                    pcf_d = pcf_plus4;
                    if (StallD) begin
                        hold_instr_d = imem_rdata;
                        hold_pc_d    = pcf_q;
                        state_d      = HOLD;
                    end else begin
                        ifid_load = 1'b1;
                        state_d   = FETCH;
                    end
                end
            end
            HOLD: begin
                ifid_load_data = '{instr: hold_instr_q, pc: hold_pc_q,
                                   pc_plus4: hold_pc_q + PC_STEP, valid: 1'b1};
                if (PCSrcE) begin
                    pcf_d   = target_aligned;
                    state_d = FETCH;
                end else if (!StallD) begin
                    ifid_load = 1'b1;
                    state_d   = FETCH;
                end
            end
            DROP: begin
                if (PCSrcE) begin
                    pcf_d = target_aligned;
                end
                if (imem_rvalid) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        grace_d = grace_q && !req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            pcf_q        <= RESET_PC;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            grace_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            pcf_q        <= pcf_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            grace_q      <= grace_d;
        end
    end

    if_id_reg #(
        .BUBBLE_INSTR(NOP_INSTR)
    ) u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall    (StallD),
        .flush    (FlushD),
        .load     (ifid_load),
        .load_data(ifid_load_data),
        .q        (ifid_out)
    );

    assign imem_req  = req;
    assign imem_addr = pcf_q & ALIGN_MASK;
    assign PCF       = pcf_q;
    assign InstrD    = ifid_out.instr;
    assign PCD       = ifid_out.pc;
    assign PCPlus4D  = ifid_out.pc_plus4;
    assign ValidD    = ifid_out.valid;

    // A response left over from before reset may land while idle; tolerate it
    // until the first post-reset request goes out.
    a_rvalid_expected: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rvalid |-> (state_q == WAIT || state_q == DROP || grace_q));

endmodule
